// File: rtl/dc_ipu_filter_core_s0_pkg.sv
// rtl/dc_ipu_filter_core_s0_pkg.sv - derived widths shared by the bicubic filter stages
package dc_ipu_filter_pkg;

  function automatic int weight_prod_width(input int weight_width);
    return 2 * weight_width;
  endfunction

  function automatic int texel_prod_width(input int color_width, input int weight_width);
    return color_width + 1 + weight_prod_width(weight_width);
  endfunction

  // Right shift that takes a product of two weights down to the output fraction
  function automatic int round_shift(input int weight_fract_width,
                                     input int weighted_color_fract_width);
    return 2 * weight_fract_width - weighted_color_fract_width;
  endfunction

  localparam int COLOR_WIDTH_DEF                = 8;
  localparam int WEIGHT_WIDTH_DEF               = 10;
  localparam int WEIGHT_FRACT_WIDTH_DEF         = 8;
  localparam int WEIGHTED_COLOR_FRACT_WIDTH_DEF = 6;
  localparam int WEIGHTED_COLOR_WIDTH_DEF       = 18;

  localparam int WEIGHT_PROD_WIDTH = weight_prod_width(WEIGHT_WIDTH_DEF);
  localparam int TEXEL_PROD_WIDTH  = texel_prod_width(COLOR_WIDTH_DEF, WEIGHT_WIDTH_DEF);
  localparam int SH = round_shift(WEIGHT_FRACT_WIDTH_DEF, WEIGHTED_COLOR_FRACT_WIDTH_DEF);

endpackage

// File: rtl/dc_ipu_filter_core_s0_if.sv
// rtl/dc_ipu_filter_core_s0_if.sv - texel/weight input and weighted-matrix output bundle
interface dc_ipu_filter_core_s0_if #(
  parameter int COLOR_WIDTH          = 8,
  parameter int WEIGHT_WIDTH         = 10,
  parameter int WEIGHTED_COLOR_WIDTH = 18
) ();

  logic                                          in_valid;
  logic                                          in_ready;
  logic [0:3][0:3][COLOR_WIDTH-1:0]              in_texel_matrix;
  logic [0:3][WEIGHT_WIDTH-1:0]                  in_weights_x;
  logic [0:3][WEIGHT_WIDTH-1:0]                  in_weights_y;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [0:3][0:3][WEIGHTED_COLOR_WIDTH-1:0]     out_weighted_texel_matrix;

  modport slave (
    input  in_valid, in_texel_matrix, in_weights_x, in_weights_y, out_ready,
    output in_ready, out_valid, out_weighted_texel_matrix
  );

  modport master (
    output in_valid, in_texel_matrix, in_weights_x, in_weights_y, out_ready,
    input  in_ready, out_valid, out_weighted_texel_matrix
  );

endinterface

// File: rtl/dc_ipu_filter_core_s0_weight_mul.sv
// rtl/dc_ipu_filter_core_s0_weight_mul.sv - one texel x weight product with round-half-up and saturation
module dc_ipu_filter_weight_mul
  import dc_ipu_filter_pkg::*;
#(
  parameter int COLOR_WIDTH                = 8,
  parameter int WEIGHT_WIDTH               = 10,
  parameter int WEIGHT_FRACT_WIDTH         = 8,
  parameter int WEIGHTED_COLOR_FRACT_WIDTH = 6,
  parameter int WEIGHTED_COLOR_WIDTH       = 18
) (
  input  logic        [COLOR_WIDTH-1:0]                    texel,
  input  logic signed [weight_prod_width(WEIGHT_WIDTH)-1:0] weight,
  output logic        [WEIGHTED_COLOR_WIDTH-1:0]           result
);

  localparam int WPW = weight_prod_width(WEIGHT_WIDTH);
  localparam int TPW = texel_prod_width(COLOR_WIDTH, WEIGHT_WIDTH);
  localparam int SHR = round_shift(WEIGHT_FRACT_WIDTH, WEIGHTED_COLOR_FRACT_WIDTH);
  localparam int WCW = WEIGHTED_COLOR_WIDTH;

  localparam logic signed [TPW:0] RND     = $signed({{TPW{1'b0}}, 1'b1} << (SHR - 1));
  localparam logic signed [TPW:0] SAT_MAX = {{(TPW - WCW + 2){1'b0}}, {(WCW - 1){1'b1}}};
  localparam logic signed [TPW:0] SAT_MIN = {{(TPW - WCW + 2){1'b1}}, {(WCW - 1){1'b0}}};

  logic signed [TPW-1:0] texel_ext;
  logic signed [TPW-1:0] weight_ext;
  logic signed [TPW-1:0] prod;
  logic signed [TPW:0]   biased;
  logic signed [TPW:0]   shifted;

  // One guard bit above the product keeps the rounding bias from wrapping
  always_comb begin
    texel_ext  = {{(TPW - COLOR_WIDTH){1'b0}}, texel};
    weight_ext = {{(TPW - WPW){weight[WPW-1]}}, weight};
    prod       = texel_ext * weight_ext;
    biased     = $signed({prod[TPW-1], prod}) + RND;
    shifted    = biased >>> SHR;
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[WCW-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[WCW-1:0];
    end else begin
      result = shifted[WCW-1:0];
    end
  end

endmodule

// File: rtl/dc_ipu_filter_core_s0.sv
// rtl/dc_ipu_filter_core_s0.sv - bicubic stage 0: per-texel weights, multiply, round, saturate
module dc_ipu_filter_core_s0
  import dc_ipu_filter_pkg::*;
#(
  parameter int COLOR_WIDTH                = 8,
  parameter int WEIGHT_WIDTH               = 10,
  parameter int WEIGHT_FRACT_WIDTH         = 8,
  parameter int WEIGHTED_COLOR_FRACT_WIDTH = 6,
  parameter int WEIGHTED_COLOR_WIDTH       = 18
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    clr,
  dc_ipu_filter_core_s0_if.slave  bus
);

  localparam int WPW = weight_prod_width(WEIGHT_WIDTH);

  typedef logic [0:3][0:3][COLOR_WIDTH-1:0]          texel_mat_t;
  typedef logic [0:3][WEIGHT_WIDTH-1:0]              weight_vec_t;
  typedef logic [0:3][0:3][WPW-1:0]                  wprod_mat_t;
  typedef logic [0:3][0:3][WEIGHTED_COLOR_WIDTH-1:0] out_mat_t;

  logic        en;

  logic        buf_v_q, buf_v_d;
  texel_mat_t  buf_tex_q, buf_tex_d;
  weight_vec_t buf_wx_q, buf_wx_d;
  weight_vec_t buf_wy_q, buf_wy_d;

  logic        side_full_q, side_full_d;
  texel_mat_t  side_tex_q, side_tex_d;
  weight_vec_t side_wx_q, side_wx_d;
  weight_vec_t side_wy_q, side_wy_d;

  logic        s0_v_q, s0_v_d;
  wprod_mat_t  s0_w_q, s0_w_d;
  texel_mat_t  s0_tex_q, s0_tex_d;

  logic        s1_v_q, s1_v_d;
  out_mat_t    s1_out_q, s1_out_d;

  logic signed [WPW-1:0] wx_ext [0:3];
  logic signed [WPW-1:0] wy_ext [0:3];
  wprod_mat_t            wprod;
  out_mat_t              mul_res;

  assign en                            = bus.out_ready;
  assign bus.in_ready                  = !side_full_q;
  assign bus.out_valid                 = s1_v_q;
  assign bus.out_weighted_texel_matrix = s1_out_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wx_ext[i] = {{(WPW - WEIGHT_WIDTH){buf_wx_q[i][WEIGHT_WIDTH-1]}}, buf_wx_q[i]};
      wy_ext[i] = {{(WPW - WEIGHT_WIDTH){buf_wy_q[i][WEIGHT_WIDTH-1]}}, buf_wy_q[i]};
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        wprod[i][j] = wx_ext[i] * wy_ext[j];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      dc_ipu_filter_weight_mul #(
        .COLOR_WIDTH                (COLOR_WIDTH),
        .WEIGHT_WIDTH               (WEIGHT_WIDTH),
        .WEIGHT_FRACT_WIDTH         (WEIGHT_FRACT_WIDTH),
        .WEIGHTED_COLOR_FRACT_WIDTH (WEIGHTED_COLOR_FRACT_WIDTH),
        .WEIGHTED_COLOR_WIDTH       (WEIGHTED_COLOR_WIDTH)
      ) u_mul (
        .texel  (s0_tex_q[gi][gj]),
        .weight (s0_w_q[gi][gj]),
        .result (mul_res[gi][gj])
      );
    end
  end

  always_comb begin
    buf_v_d     = buf_v_q;
    buf_tex_d   = buf_tex_q;
    buf_wx_d    = buf_wx_q;
    buf_wy_d    = buf_wy_q;
    side_full_d = side_full_q;
    side_tex_d  = side_tex_q;
    side_wx_d   = side_wx_q;
    side_wy_d   = side_wy_q;
    s0_v_d      = s0_v_q;
    s0_w_d      = s0_w_q;
    s0_tex_d    = s0_tex_q;
    s1_v_d      = s1_v_q;
    s1_out_d    = s1_out_q;

    if (clr) begin
      buf_v_d     = 1'b0;
      side_full_d = 1'b0;
      s0_v_d      = 1'b0;
      s1_v_d      = 1'b0;
    end else if (en) begin
      if (side_full_q) begin
        buf_v_d     = 1'b1;
        buf_tex_d   = side_tex_q;
        buf_wx_d    = side_wx_q;
        buf_wy_d    = side_wy_q;
        side_full_d = 1'b0;
      end else begin
        buf_v_d   = bus.in_valid;
        buf_tex_d = bus.in_texel_matrix;
        buf_wx_d  = bus.in_weights_x;
        buf_wy_d  = bus.in_weights_y;
      end
      s0_v_d   = buf_v_q;
      s0_w_d   = wprod;
      s0_tex_d = buf_tex_q;
      s1_v_d   = s0_v_q;
      s1_out_d = mul_res;
    end else if (bus.in_valid && !side_full_q) begin
      // Pipeline frozen: park the beat that was already granted by in_ready
      side_full_d = 1'b1;
      side_tex_d  = bus.in_texel_matrix;
      side_wx_d   = bus.in_weights_x;
      side_wy_d   = bus.in_weights_y;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_v_q     <= 1'b0;
      buf_tex_q   <= '0;
      buf_wx_q    <= '0;
      buf_wy_q    <= '0;
      side_full_q <= 1'b0;
      side_tex_q  <= '0;
      side_wx_q   <= '0;
      side_wy_q   <= '0;
      s0_v_q      <= 1'b0;
      s0_w_q      <= '0;
      s0_tex_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_out_q    <= '0;
    end else begin
      buf_v_q     <= buf_v_d;
      buf_tex_q   <= buf_tex_d;
      buf_wx_q    <= buf_wx_d;
      buf_wy_q    <= buf_wy_d;
      side_full_q <= side_full_d;
      side_tex_q  <= side_tex_d;
      side_wx_q   <= side_wx_d;
      side_wy_q   <= side_wy_d;
      s0_v_q      <= s0_v_d;
      s0_w_q      <= s0_w_d;
      s0_tex_q    <= s0_tex_d;
      s1_v_q      <= s1_v_d;
      s1_out_q    <= s1_out_d;
    end
  end

endmodule

// File: tb/tb_dc_ipu_filter_core_s0.sv
// tb/tb_dc_ipu_filter_core_s0.sv - directed scoreboard bench for bicubic stage 0
module tb_dc_ipu_filter_core_s0;
  import dc_ipu_filter_pkg::*;

  typedef logic [0:3][0:3][7:0]  tex_t;
  typedef logic [0:3][9:0]       wv_t;
  typedef logic [0:3][0:3][17:0] mat_t;

  localparam int MSH = round_shift(8, 6);

  logic clk;
  logic nreset;
  logic clr;
  int   total;
  int   bad;
  mat_t exp_q[$];
  bit   hold;
  mat_t held;

  dc_ipu_filter_core_s0_if #(.COLOR_WIDTH(8), .WEIGHT_WIDTH(10), .WEIGHTED_COLOR_WIDTH(18)) ifa ();
  dc_ipu_filter_core_s0_if #(.COLOR_WIDTH(8), .WEIGHT_WIDTH(10), .WEIGHTED_COLOR_WIDTH(14)) ifb ();

  dc_ipu_filter_core_s0 #(.WEIGHTED_COLOR_WIDTH(18)) dut_a (
    .clk(clk), .nreset(nreset), .clr(clr), .bus(ifa)
  );
  dc_ipu_filter_core_s0 #(.WEIGHTED_COLOR_WIDTH(14)) dut_b (
    .clk(clk), .nreset(nreset), .clr(clr), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mat_t model(input tex_t t, input wv_t wx, input wv_t wy);
    mat_t   m;
    longint p;
    longint r;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        p = longint'(t[i][j]) * longint'($signed(wx[i])) * longint'($signed(wy[j]));
        r = (p + (64'sd1 <<< (MSH - 1))) >>> MSH;
        if (r > 131071) r = 131071;
        else if (r < -131072) r = -131072;
        m[i][j] = r[17:0];
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input tex_t t, input wv_t wx, input wv_t wy, input logic v);
    ifa.in_texel_matrix = t;
    ifa.in_weights_x    = wx;
    ifa.in_weights_y    = wy;
    ifa.in_valid        = v;
    ifb.in_texel_matrix = t;
    ifb.in_weights_x    = wx;
    ifb.in_weights_y    = wy;
    ifb.in_valid        = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input tex_t t, input wv_t wx, input wv_t wy);
    drive(t, wx, wy, 1'b1);
    tick();
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ifa.out_valid) begin
        lat = n;
        break;
      end
    end
    chk("out_timeout", longint'(lat != 0), 1);
  endtask

  // Scoreboard: push on input handshake, pop on output handshake, hold check while stalled
  always @(negedge clk) begin
    if (!nreset || clr) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        total++;
        assert (ifa.out_valid === 1'b1 && ifa.out_weighted_texel_matrix === held)
        else begin
          bad++;
          $error("FAIL stall_stable observed=%0b/%h expected=1/%h", ifa.out_valid,
                 ifa.out_weighted_texel_matrix, held);
        end
      end
      hold = ifa.out_valid && !ifa.out_ready;
      held = ifa.out_weighted_texel_matrix;
      if (ifa.out_valid && ifa.out_ready) begin
        total++;
        assert (exp_q.size() > 0)
        else begin
          bad++;
          $error("FAIL sb_unexpected observed=output expected=none");
        end
        if (exp_q.size() > 0) begin
          mat_t e;
          e = exp_q.pop_front();
          total++;
          assert (ifa.out_weighted_texel_matrix === e)
          else begin
            bad++;
            $error("FAIL sb_data observed=%h expected=%h", ifa.out_weighted_texel_matrix, e);
          end
        end
      end
      if (ifa.in_valid && ifa.in_ready)
        exp_q.push_back(model(ifa.in_texel_matrix, ifa.in_weights_x, ifa.in_weights_y));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    tex_t t;
    wv_t  wx;
    wv_t  wy;
    tex_t bt [8];
    wv_t  bx [8];
    wv_t  by [8];
    int   lat;
    int   k;
    bit   acc;
    mat_t e;

    total = 0;
    bad   = 0;
    clr   = 1'b0;
    nreset = 1'b0;
    drive('0, '0, '0, 1'b0);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_mat_nonzero", longint'(ifa.out_weighted_texel_matrix != '0), 0);
    nreset = 1'b1;
    tick();
    chk("rst_in_ready", ifa.in_ready, 1);
    chk("rst_out_valid_after", ifa.out_valid, 0);

    // Identity weight at [1][1]
    t = {16{8'd99}};
    t[1][1] = 8'd200;
    wx = '0;
    wx[1] = 10'd256;
    wy = wx;
    send1(t, wx, wy);
    wait_out(lat);
    chk("latency", lat, 3);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("identity_%0d_%0d", i, j),
            longint'($signed(ifa.out_weighted_texel_matrix[i][j])),
            (i == 1 && j == 1) ? 12800 : 0);

    // Negative weight
    tick();
    t = '0;
    t[0][0] = 8'd255;
    wx = '0;
    wx[0] = -10'sd32;
    wy = '0;
    wy[0] = 10'd256;
    send1(t, wx, wy);
    wait_out(lat);
    chk("negative_0_0", longint'($signed(ifa.out_weighted_texel_matrix[0][0])), -2040);
    chk("negative_1_0", longint'($signed(ifa.out_weighted_texel_matrix[1][0])), 0);

    // Rounding of +0.5 and -0.5
    tick();
    t = {16{8'd2}};
    wx = '0;
    wx[0] = 10'd16;
    wy = '0;
    wy[0] = 10'd16;
    send1(t, wx, wy);
    wait_out(lat);
    chk("round_pos_half", longint'($signed(ifa.out_weighted_texel_matrix[0][0])), 1);
    chk("round_pos_other", longint'($signed(ifa.out_weighted_texel_matrix[0][1])), 0);
    tick();
    wx[0] = -10'sd16;
    send1(t, wx, wy);
    wait_out(lat);
    chk("round_neg_half", longint'($signed(ifa.out_weighted_texel_matrix[0][0])), 0);

    // Full-scale negatives: 14-bit instance saturates, 18-bit instance holds 65280
    tick();
    t = {16{8'd255}};
    wx = {4{10'h200}};
    wy = wx;
    send1(t, wx, wy);
    wait_out(lat);
    chk("sat_b_valid", ifb.out_valid, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("sat_b_%0d_%0d", i, j),
            longint'($signed(ifb.out_weighted_texel_matrix[i][j])), 8191);
        chk($sformatf("fullscale_a_%0d_%0d", i, j),
            longint'($signed(ifa.out_weighted_texel_matrix[i][j])), 65280);
      end

    // Backpressure: 8 random beats with a 5-cycle stall
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) begin
        bx[n][i] = 10'($urandom_range(0, 1023));
        by[n][i] = 10'($urandom_range(0, 1023));
        for (int j = 0; j < 4; j++) bt[n][i][j] = 8'($urandom_range(0, 255));
      end
    end
    tick();
    k = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      ifa.out_ready = !(cyc >= 3 && cyc <= 7);
      if (k < 8) drive(bt[k], bx[k], by[k], 1'b1);
      else drive('0, '0, '0, 1'b0);
      @(negedge clk);
      chk($sformatf("bp_in_ready_c%0d", cyc), ifa.in_ready, (cyc >= 4 && cyc <= 8) ? 0 : 1);
      acc = ifa.in_valid && ifa.in_ready;
      tick();
      if (acc) k++;
    end
    chk("bp_beats_sent", k, 8);
    chk("bp_drained", exp_q.size(), 0);

    // clr with beats in flight; the beat offered alongside clr is discarded
    drive(bt[0], bx[0], by[0], 1'b1);
    tick();
    drive(bt[1], bx[1], by[1], 1'b1);
    tick();
    drive(bt[2], bx[2], by[2], 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive('0, '0, '0, 1'b0);
    chk("clr_out_valid", ifa.out_valid, 0);
    chk("clr_in_ready", ifa.in_ready, 1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("clr_quiet_%0d", n), ifa.out_valid, 0);
    end
    tick();
    send1(bt[3], bx[3], by[3]);
    wait_out(lat);
    chk("clr_next_latency", lat, 3);
    e = model(bt[3], bx[3], by[3]);
    total++;
    assert (ifa.out_weighted_texel_matrix === e)
    else begin
      bad++;
      $error("FAIL clr_next_data observed=%h expected=%h", ifa.out_weighted_texel_matrix, e);
    end

    // Asynchronous reset with two beats in flight
    tick();
    drive(bt[4], bx[4], by[4], 1'b1);
    tick();
    drive(bt[5], bx[5], by[5], 1'b1);
    tick();
    drive('0, '0, '0, 1'b0);
    #2;
    nreset = 1'b0;
    #1;
    chk("arst_out_valid", ifa.out_valid, 0);
    chk("arst_out_mat_nonzero", longint'(ifa.out_weighted_texel_matrix != '0), 0);
    chk("arst_in_ready", ifa.in_ready, 1);
    tick();
    nreset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("arst_quiet_%0d", n), ifa.out_valid, 0);
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
